dout_serialiser: RTL and testbench
==================================

# dout_serialiser

Output-side peripheral for the 8-bit teaching CPU. Consumes the CPU's `Dout` byte bus and `Dval` strobe (both driven from CPU registers in the same clock domain) and queues each strobed byte in a small FIFO. Transmits queued bytes LSB-first on a single asynchronous serial line in 8N1 format. Reports occupancy and overflow status back to the board.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `DEPTH_LOG2`, 2, log2 of FIFO depth (default depth 4).
- `clock  in  1  system clock, same domain as the CPU`
- `Reset  in  1  reset Reset, synchronous, active-high; clock clock`
- `Dout   in  8  byte presented by the CPU`
- `Dval   in  1  CPU data-valid level; a 0->1 transition requests one push`
- `Tx     out 1  serial line, idle high`
- `Busy   out 1  high while a frame is in flight or the FIFO is non-empty`
- `Full   out 1  FIFO holds 2^DEPTH_LOG2 entries`
- `Ovf    out 1  sticky: a push was dropped because the FIFO was full`
- `Count  out DEPTH_LOG2+1  current FIFO occupancy`

## Operation
- Edge detect: register `Dval` into `dval_d`. A push request is `Dval & ~dval_d`. `Dout` is sampled in that same cycle. Holding `Dval` high produces exactly one push. No synchroniser is used, because the inputs come from the same clock domain.
- FIFO: circular buffer with read and write pointers of width DEPTH_LOG2 that wrap modulo depth, plus an occupancy counter.
  - Push when not full: write the entry and increment `Count`.
  - Push when full with no pop in the same cycle: drop the byte and set `Ovf`. `Ovf` clears only on Reset.
  - Push and pop in the same cycle: both take effect and `Count` is unchanged. This holds even when the FIFO is full, in which case the push is accepted.
- TX FSM states are IDLE, START, DATA, STOP.
  - IDLE: `Tx`=1. If `Count`>0, pop the head into a 8-bit shift register, clear the bit counter and the baud counter, then go to START.
  - START: `Tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `Tx`=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After 8 bits, go to STOP (or PARITY, see Configuration).
  - STOP: `Tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. The state advances on the wrap.
- `Busy` = (state != IDLE) | (`Count` != 0).
- `Full` = (`Count` == 2^DEPTH_LOG2).

## Timing
- Reset values: `Tx`=1, `Busy`=0, `Full`=0, `Ovf`=0, `Count`=0, state IDLE, pointers 0, `dval_d`=0.
- Reset mid-frame: the frame is aborted and the FIFO is emptied. `Tx` is 1 from the first edge after Reset is asserted.
- Push latency: `Dval` rises in cycle N; `Count` increments at edge N+1.
- Pop latency: with an empty FIFO and IDLE state, a push in cycle N gives IDLE seeing `Count`=1 in cycle N+1. The pop occurs at edge N+2, and `Tx` goes low from cycle N+2.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity).
- Back-to-back frames: exactly one IDLE cycle (`Tx`=1) between the end of STOP and the next START.
- Outputs are all registered, or decoded from registered state only.

## Configuration
- Macro: `DOUT_SERIALISER_PARITY_EN`.
- Defined: a PARITY state is inserted between DATA and STOP.
  - `Tx` = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - The frame becomes 11 bits (8E1).
- Undefined: there is no PARITY state and the frame is 8N1. No parity logic is synthesised.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DEPTH_LOG2=2.
- Single byte:
  - Stimulus: `Dout`=0xA5, `Dval` pulse in cycle 10.
  - Response: `Tx` low from cycle 12. Bit sequence at 4 cycles/bit is 0,1,0,1,0,0,1,0,1,1. `Tx` is high from cycle 52. `Busy` falls at cycle 52.
- Level hold:
  - Stimulus: `Dval` held high for 100 cycles with `Dout`=0x3C.
  - Response: exactly one frame (start bit, then 0,0,1,1,1,1,0,0, then stop bit). `Count` never exceeds 1.
- Overflow:
  - Stimulus: 6 `Dval` pulses, each high 1 cycle and low 1 cycle, bytes 0x01..0x06.
  - Response: 0x01 is popped immediately and 0x02..0x05 fill the FIFO, so `Full`=1. 0x06 is dropped and `Ovf`=1. Exactly 5 frames are transmitted, in order 0x01..0x05. `Ovf` stays 1 afterwards.
- Full push+pop:
  - Stimulus: FIFO full, then a push coincident with the IDLE pop cycle.
  - Response: `Count` stays 4, the byte is accepted, and `Ovf` stays 0.
- Reset mid-frame:
  - Stimulus: assert Reset during DATA bit 3 with 2 bytes queued.
  - Response: next cycle `Tx`=1, `Count`=0, `Busy`=0, `Ovf`=0. No further frames are sent.
- Parity (macro defined):
  - Stimulus: send 0xA5, then 0x07.
  - Response: parity bit 0 for 0xA5 and 1 for 0x07. Frame length is 44 cycles.

Source files
------------

// File: rtl/dout_serialiser.sv
// dout_serialiser: queues bytes strobed by the CPU (Dout/Dval) in a small FIFO
// and transmits them LSB-first on Tx as 8N1 frames.
// Optional macro DOUT_SERIALISER_PARITY_EN inserts an even-parity bit (8E1).
module dout_serialiser #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                  clock,
  input  logic                  Reset,
  input  logic [7:0]            Dout,
  input  logic                  Dval,
  output logic                  Tx,
  output logic                  Busy,
  output logic                  Full,
  output logic                  Ovf,
  output logic [DEPTH_LOG2:0]   Count
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [15:0]         BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

`ifdef DOUT_SERIALISER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

  tx_state_t             state;
  tx_state_t             state_next;
  logic                  dval_d;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [7:0]            fifo_mem [DEPTH];
  logic [15:0]           baud_cnt;
  logic                  baud_wrap;
  logic [2:0]            bit_idx;
  logic [7:0]            shift_reg;
`ifdef DOUT_SERIALISER_PARITY_EN
  logic                  parity_bit;
`endif

  // A push is the rising edge of Dval; a pop happens whenever the idle FSM sees data.
  // When full, a push is still accepted if a pop frees a slot in the same cycle.
  assign push_req  = Dval & ~dval_d;
  assign pop       = (state == IDLE) && (Count != '0);
  assign push_ok   = push_req && (!Full || pop);
  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign Full      = (Count == COUNT_FULL);
  assign Busy      = (state != IDLE) || (Count != '0);

  // Delay Dval by one cycle for rising-edge detection (same clock domain, no synchroniser).
  always_ff @(posedge clock) begin
    if (Reset) dval_d <= 1'b0;
    else       dval_d <= Dval;
  end

  // FIFO storage; contents need no reset since pointers and count are cleared.
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= Dout;
  end

  // FIFO pointers, occupancy counter and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   Count <= Count + COUNT_ONE;
        2'b01:   Count <= Count - COUNT_ONE;
        default: Count <= Count;
      endcase
      if (push_req && Full && !pop) Ovf <= 1'b1;
    end
  end

  // Transmit FSM state register.
  always_ff @(posedge clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: every non-idle state lasts one bit time, DATA lasts eight.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (pop) state_next = START;
      START: if (baud_wrap) state_next = DATA;
`ifdef DOUT_SERIALISER_PARITY_EN
      DATA:   if (baud_wrap && bit_idx == 3'd7) state_next = PARITY;
      PARITY: if (baud_wrap) state_next = STOP;
`else
      DATA:  if (baud_wrap && bit_idx == 3'd7) state_next = STOP;
`endif
      STOP:  if (baud_wrap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bit-time counter, data bit index and shift register loaded from the FIFO head.
  always_ff @(posedge clock) begin
    if (Reset) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef DOUT_SERIALISER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      if (pop) begin
        shift_reg <= fifo_mem[rd_ptr];
`ifdef DOUT_SERIALISER_PARITY_EN
        parity_bit <= ^fifo_mem[rd_ptr];
`endif
      end
    end else begin
      baud_cnt <= baud_wrap ? '0 : baud_cnt + 16'd1;
      if (state == DATA && baud_wrap) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + 3'd1;
      end
    end
  end

  // Serial line decoded from registered state only; idle and stop are high.
  always_comb begin
    Tx = 1'b1;
    case (state)
      START:   Tx = 1'b0;
      DATA:    Tx = shift_reg[0];
`ifdef DOUT_SERIALISER_PARITY_EN
      PARITY:  Tx = parity_bit;
`endif
      default: Tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_dout_serialiser.sv
// tb_dout_serialiser: directed stimulus with a byte scoreboard; a serial-line
// monitor decodes each frame and compares it with the next expected byte.
module tb_dout_serialiser;

  localparam int CLKS_PER_BIT = 4;
  localparam int DEPTH_LOG2   = 2;
`ifdef DOUT_SERIALISER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;

  logic                clock = 1'b0;
  logic                reset;
  logic [7:0]          dout;
  logic                dval;
  logic                tx;
  logic                busy;
  logic                full;
  logic                ovf;
  logic [DEPTH_LOG2:0] count;

  int         check_count = 0;
  int         pass_count  = 0;
  int         fail_count  = 0;
  int         frames_seen = 0;
  bit         monitor_en  = 1'b1;
  logic [7:0] sb [$];

  dout_serialiser #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DEPTH_LOG2  (DEPTH_LOG2)
  ) dut (
    .clock(clock),
    .Reset(reset),
    .Dout (dout),
    .Dval (dval),
    .Tx   (tx),
    .Busy (busy),
    .Full (full),
    .Ovf  (ovf),
    .Count(count)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Rising Dval with a byte, held for high_cycles then low for low_cycles.
  task automatic applyStimulus(input logic [7:0] data, input int high_cycles, input int low_cycles, input bit accept);
    dout = data;
    dval = 1'b1;
    if (accept) sb.push_back(data);
    stepCycles(high_cycles);
    dval = 1'b0;
    stepCycles(low_cycles);
  endtask

  // Wait (bounded) for Busy to drop.
  task automatic waitIdle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      stepCycles(1);
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  // Serial monitor: detect a start edge and sample every bit in its middle.
  initial begin
    logic       prev_tx;
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    prev_tx = 1'b1;
    forever begin
      @(negedge clock);
      if (monitor_en && tx === 1'b0 && prev_tx === 1'b1) begin
        rx_byte = '0;
        stepCycles(CLKS_PER_BIT / 2);
        checkOutput("start_bit", 32'(tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
          stepCycles(CLKS_PER_BIT);
          rx_byte[k] = tx;
        end
`ifdef DOUT_SERIALISER_PARITY_EN
        stepCycles(CLKS_PER_BIT);
        checkOutput("parity_bit", 32'(tx), 32'(^rx_byte));
`endif
        stepCycles(CLKS_PER_BIT);
        checkOutput("stop_bit", 32'(tx), 32'd1);
        checkOutput("frame_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_byte = sb.pop_front();
          checkOutput("frame_data", 32'(rx_byte), 32'(exp_byte));
        end
        frames_seen++;
      end
      prev_tx = tx;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    int frames_before;
    int max_count;
    int low_cycles;

    reset = 1'b1;
    dval  = 1'b0;
    dout  = 8'h00;
    stepCycles(3);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_count", 32'(count), 32'd0);
    reset = 1'b0;
    stepCycles(1);
    checkOutput("idle_tx", 32'(tx), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_full", 32'(full), 32'd0);
    checkOutput("idle_ovf", 32'(ovf), 32'd0);
    checkOutput("idle_count", 32'(count), 32'd0);

    $display("[TB] single byte 0xA5");
    applyStimulus(8'hA5, 1, 0, 1'b1);
    checkOutput("push_latency_count", 32'(count), 32'd1);
    checkOutput("pre_start_tx", 32'(tx), 32'd1);
    checkOutput("busy_on_push", 32'(busy), 32'd1);
    stepCycles(1);
    checkOutput("start_tx_low", 32'(tx), 32'd0);
    checkOutput("count_after_pop", 32'(count), 32'd0);
    stepCycles(FRAME_CYCLES - 1);
    checkOutput("busy_last_stop", 32'(busy), 32'd1);
    checkOutput("tx_last_stop", 32'(tx), 32'd1);
    stepCycles(1);
    checkOutput("busy_fall", 32'(busy), 32'd0);
    checkOutput("frames_single", 32'(frames_seen), 32'd1);

    $display("[TB] level hold 0x3C");
    dout = 8'h3C;
    dval = 1'b1;
    sb.push_back(8'h3C);
    max_count = 0;
    for (int i = 0; i < 100; i++) begin
      stepCycles(1);
      if (int'(count) > max_count) max_count = int'(count);
    end
    dval = 1'b0;
    stepCycles(20);
    checkOutput("hold_max_count", 32'(max_count), 32'd1);
    checkOutput("hold_frames", 32'(frames_seen), 32'd2);
    checkOutput("hold_busy", 32'(busy), 32'd0);

    $display("[TB] overflow");
    frames_before = frames_seen;
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1, 1, 1'b1);
    checkOutput("ovf_fill_count", 32'(count), 32'd4);
    checkOutput("ovf_fill_full", 32'(full), 32'd1);
    checkOutput("ovf_before_drop", 32'(ovf), 32'd0);
    applyStimulus(8'h06, 1, 1, 1'b0);
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    checkOutput("ovf_count_held", 32'(count), 32'd4);
    waitIdle("ovf_drain", 600);
    stepCycles(5);
    checkOutput("ovf_frames", 32'(frames_seen - frames_before), 32'd5);
    checkOutput("ovf_sticky", 32'(ovf), 32'd1);
    checkOutput("ovf_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("ovf_full_clear", 32'(full), 32'd0);

    reset = 1'b1;
    stepCycles(2);
    reset = 1'b0;
    stepCycles(1);
    checkOutput("ovf_reset_clear", 32'(ovf), 32'd0);

    $display("[TB] full push+pop");
    frames_before = frames_seen;
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h10 + i), 1, 1, 1'b1);
    checkOutput("pp_full_count", 32'(count), 32'd4);
    checkOutput("pp_full_flag", 32'(full), 32'd1);
    stepCycles(FRAME_CYCLES + 2 - 10);
    checkOutput("pp_idle_gap_tx", 32'(tx), 32'd1);
    applyStimulus(8'h5A, 1, 0, 1'b1);
    checkOutput("pp_count_kept", 32'(count), 32'd4);
    checkOutput("pp_ovf_clear", 32'(ovf), 32'd0);
    checkOutput("pp_full_kept", 32'(full), 32'd1);
    checkOutput("pp_next_start", 32'(tx), 32'd0);
    waitIdle("pp_drain", 600);
    stepCycles(5);
    checkOutput("pp_frames", 32'(frames_seen - frames_before), 32'd6);
    checkOutput("pp_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("pp_ovf_final", 32'(ovf), 32'd0);

    $display("[TB] reset mid-frame");
    monitor_en = 1'b0;
    applyStimulus(8'hF7, 1, 1, 1'b0);
    applyStimulus(8'h22, 1, 1, 1'b0);
    applyStimulus(8'h33, 1, 1, 1'b0);
    stepCycles(13);
    checkOutput("mid_bit3_tx", 32'(tx), 32'd0);
    checkOutput("mid_count", 32'(count), 32'd2);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    stepCycles(1);
    checkOutput("mid_reset_tx", 32'(tx), 32'd1);
    checkOutput("mid_reset_count", 32'(count), 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    checkOutput("mid_reset_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    low_cycles = 0;
    for (int i = 0; i < 80; i++) begin
      stepCycles(1);
      if (tx !== 1'b1) low_cycles++;
    end
    checkOutput("mid_no_more_frames", 32'(low_cycles), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
